cpri_txdata_buffer: RTL and testbench

- Transmit-side counterpart of the CPRI RX buffer.
- Collects beam-reduced 64-bit words arriving in 96-word chunks (chunk address 0..95 plus last flag) into a two-bank ping-pong RAM, one symbol block per bank.
- Replays each completed block to the CPRI TX framer at the framer's slot cadence, tagging every word with a chunk sequence number and start/end markers.

---
 rtl/cpri_tx_pkg.sv | 14 +
 rtl/pingpong_ram_2bank.sv | 27 ++
 rtl/cpri_txdata_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_cpri_txdata_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpri_tx_pkg.sv
// Shared constants and read-FSM encoding for the CPRI TX data buffer.
package cpri_tx_pkg;

  localparam int CHUNK_WORDS  = 96;
  localparam int BLOCK_CHUNKS = 33;
  localparam int BLOCK_WORDS  = CHUNK_WORDS * BLOCK_CHUNKS;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BUSY  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pingpong_ram_2bank.sv
// Simple dual-port RAM holding two banks; the address MSB selects the bank.
// Read data appears READ_LATENCY cycles after the read address is presented.
module pingpong_ram_2bank #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH:0]   i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q     [2**(ADDR_WIDTH+1)];
  logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    rd_pipe_q[0] <= mem_q[i_raddr];
    for (int k = 1; k < READ_LATENCY; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
  end

  assign o_rdata = rd_pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/cpri_txdata_buffer.sv
// Collects 96-word chunks into a two-bank ping-pong RAM and replays each
// completed symbol block to the CPRI TX framer at its read-slot cadence.
module cpri_txdata_buffer
  import cpri_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int CHUNK_WORDS  = cpri_tx_pkg::CHUNK_WORDS,
  parameter int BLOCK_CHUNKS = cpri_tx_pkg::BLOCK_CHUNKS,
  parameter int READ_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [6:0]            i_rx_addr,
  input  logic                  i_rx_last,
  input  logic                  i_rx_valid,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [6:0]            o_tx_seq,
  output logic                  o_tx_sop,
  output logic                  o_tx_eop,
  output logic                  o_tvalid,
  output logic                  o_overflow,
  output logic                  o_chunk_err
);

  localparam int BLK_WORDS = CHUNK_WORDS * BLOCK_CHUNKS;
  localparam int CC_W      = $clog2(BLOCK_CHUNKS);
  localparam int DC_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              bank_full_q, bank_full_d;
  logic [CC_W-1:0]         chunk_cnt_q, chunk_cnt_d;
  rd_state_e               rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DC_W-1:0]         drain_cnt_q, drain_cnt_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] sop_pipe_q, sop_pipe_d;
  logic [READ_LATENCY-1:0] eop_pipe_q, eop_pipe_d;
  logic [DATA_WIDTH-1:0]   o_tx_data_q, o_tx_data_d;
  logic [6:0]              o_tx_seq_q, o_tx_seq_d;
  logic                    o_tx_sop_q, o_tx_sop_d;
  logic                    o_tx_eop_q, o_tx_eop_d;
  logic                    o_tvalid_q, o_tvalid_d;
  logic                    o_overflow_q, o_overflow_d;
  logic                    o_chunk_err_q, o_chunk_err_d;

  logic                    ram_we;
  logic [ADDR_WIDTH:0]     ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    issue;
  logic [1:0]              set_full, clr_full;

  pingpong_ram_2bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(ram_waddr),
    .i_wdata(i_rx_data),
    .i_raddr(ram_raddr),
    .o_rdata(ram_rdata)
  );

  always_comb begin
    // write side
    wr_bank_d     = wr_bank_q;
    chunk_cnt_d   = chunk_cnt_q;
    set_full      = '0;
    clr_full      = '0;
    o_overflow_d  = 1'b0;
    o_chunk_err_d = 1'b0;
    ram_we        = i_rx_valid & ~bank_full_q[wr_bank_q];
    ram_waddr     = {wr_bank_q,
                     ADDR_WIDTH'(32'(chunk_cnt_q) * 32'(CHUNK_WORDS) + 32'(i_rx_addr))};
    if (i_rx_valid && bank_full_q[wr_bank_q]) o_overflow_d = 1'b1;
    if (ram_we && i_rx_last) begin
      o_chunk_err_d = (i_rx_addr != 7'(CHUNK_WORDS-1));
      if (chunk_cnt_q == CC_W'(BLOCK_CHUNKS-1)) begin
        chunk_cnt_d         = '0;
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        chunk_cnt_d = chunk_cnt_q + CC_W'(1);
      end
    end

    // read side
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    drain_cnt_d = drain_cnt_q;
    issue       = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_state_d = RD_BUSY;
          rd_addr_d  = '0;
        end
      end
      RD_BUSY: begin
        if (i_tready) begin
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          if (rd_addr_q == ADDR_WIDTH'(BLK_WORDS-1)) begin
            rd_state_d  = RD_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      RD_DRAIN: begin
        // bank is released only once its last read has left the RAM pipeline
        if (drain_cnt_q == DC_W'(READ_LATENCY-1)) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          rd_state_d          = RD_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    bank_full_d = (bank_full_q | set_full) & ~clr_full;
    ram_raddr   = {rd_bank_q, rd_addr_q};

    // sideband travels alongside the RAM read pipeline
    vld_pipe_d    = '0;
    sop_pipe_d    = '0;
    eop_pipe_d    = '0;
    vld_pipe_d[0] = issue;
    sop_pipe_d[0] = issue && (rd_addr_q == '0);
    eop_pipe_d[0] = issue && (rd_addr_q == ADDR_WIDTH'(BLK_WORDS-1));
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      sop_pipe_d[k] = sop_pipe_q[k-1];
      eop_pipe_d[k] = eop_pipe_q[k-1];
    end

    o_tvalid_d  = vld_pipe_q[READ_LATENCY-1];
    o_tx_sop_d  = sop_pipe_q[READ_LATENCY-1];
    o_tx_eop_d  = eop_pipe_q[READ_LATENCY-1];
    o_tx_data_d = o_tx_data_q;
    o_tx_seq_d  = o_tx_seq_q;
    if (o_tvalid_d) begin
      o_tx_data_d = ram_rdata;
      if (o_tx_sop_d || (o_tx_seq_q == 7'(CHUNK_WORDS-1))) o_tx_seq_d = '0;
      else                                                  o_tx_seq_d = o_tx_seq_q + 7'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      chunk_cnt_q   <= '0;
      rd_state_q    <= RD_IDLE;
      rd_addr_q     <= '0;
      drain_cnt_q   <= '0;
      vld_pipe_q    <= '0;
      sop_pipe_q    <= '0;
      eop_pipe_q    <= '0;
      o_tx_data_q   <= '0;
      o_tx_seq_q    <= '0;
      o_tx_sop_q    <= 1'b0;
      o_tx_eop_q    <= 1'b0;
      o_tvalid_q    <= 1'b0;
      o_overflow_q  <= 1'b0;
      o_chunk_err_q <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      chunk_cnt_q   <= chunk_cnt_d;
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      drain_cnt_q   <= drain_cnt_d;
      vld_pipe_q    <= vld_pipe_d;
      sop_pipe_q    <= sop_pipe_d;
      eop_pipe_q    <= eop_pipe_d;
      o_tx_data_q   <= o_tx_data_d;
      o_tx_seq_q    <= o_tx_seq_d;
      o_tx_sop_q    <= o_tx_sop_d;
      o_tx_eop_q    <= o_tx_eop_d;
      o_tvalid_q    <= o_tvalid_d;
      o_overflow_q  <= o_overflow_d;
      o_chunk_err_q <= o_chunk_err_d;
    end
  end

  assign o_tx_data   = o_tx_data_q;
  assign o_tx_seq    = o_tx_seq_q;
  assign o_tx_sop    = o_tx_sop_q;
  assign o_tx_eop    = o_tx_eop_q;
  assign o_tvalid    = o_tvalid_q;
  assign o_overflow  = o_overflow_q;
  assign o_chunk_err = o_chunk_err_q;

endmodule

// File: tb/tb_cpri_txdata_buffer.sv
// Scoreboard bench for cpri_txdata_buffer: stimulus pushes expected words,
// a free-running monitor pops and compares on every o_tvalid.
module tb_cpri_txdata_buffer;
  import cpri_tx_pkg::*;

  localparam int BLK = BLOCK_WORDS;
  localparam int CW  = CHUNK_WORDS;
  localparam int NCH = BLOCK_CHUNKS;

  typedef struct packed {
    logic [63:0] data;
    logic [6:0]  seq;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] rx_data;
  logic [6:0]  rx_addr;
  logic        rx_last;
  logic        rx_valid;
  logic        tready;
  logic [63:0] tx_data;
  logic [6:0]  tx_seq;
  logic        tx_sop, tx_eop, tvalid, overflow, chunk_err;

  exp_t sb[$];
  int   sop_q[$];
  int   eop_q[$];
  int   n_pass = 0, n_total = 0;
  int   cyc = 0, n_words = 0, n_ovf = 0, ovf_first = -1, n_cerr = 0, cerr_cyc = -1;
  int   prev_vld = -1;
  bit   chk_gap = 0;
  int   wr_first_cyc = 0, wr_last_cyc = 0, cerr_last_cyc = 0;

  cpri_txdata_buffer dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_data  (rx_data),
    .i_rx_addr  (rx_addr),
    .i_rx_last  (rx_last),
    .i_rx_valid (rx_valid),
    .i_tready   (tready),
    .o_tx_data  (tx_data),
    .o_tx_seq   (tx_seq),
    .o_tx_sop   (tx_sop),
    .o_tx_eop   (tx_eop),
    .o_tvalid   (tvalid),
    .o_overflow (overflow),
    .o_chunk_err(chunk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (overflow) begin
        n_ovf++;
        if (ovf_first < 0) ovf_first = cyc;
      end
      if (chunk_err) begin
        n_cerr++;
        cerr_cyc = cyc;
      end
      if (tvalid) begin
        n_words++;
        if (sb.size() == 0) begin
          check("tvalid_with_empty_scoreboard", tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("tx_word{data,seq,sop,eop}", {tx_data, tx_seq, tx_sop, tx_eop}, e);
        end
        if (tx_sop) sop_q.push_back(cyc);
        if (tx_eop) eop_q.push_back(cyc);
        if (chk_gap && !tx_sop && prev_vld >= 0) check("tvalid_spacing", cyc - prev_vld, 2);
        prev_vld = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
    end
  endtask

  // Writes one full block; with cerr, chunk 0 is sent out of order so its
  // last flag lands on address 50 while all 96 words are still written.
  task automatic write_block(input logic [63:0] base, input bit push, input bit cerr);
    exp_t e;
    if (push) begin
      for (int i = 0; i < BLK; i++) begin
        e.data = base + 64'(i);
        e.seq  = 7'(i % CW);
        e.sop  = (i == 0);
        e.eop  = (i == BLK - 1);
        sb.push_back(e);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < CW; k++) begin
        int a;
        a = k;
        if (cerr && c == 0) a = (k < 50) ? k : ((k < CW - 1) ? k + 1 : 50);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_addr  = 7'(a);
        rx_data  = base + 64'(c * CW + a);
        rx_last  = (k == CW - 1);
        if (c == 0 && k == 0) wr_first_cyc = cyc;
        if (cerr && c == 0 && k == CW - 1) cerr_last_cyc = cyc;
        wr_last_cyc = cyc;
      end
    end
  endtask

  task automatic settle(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    idle(8);
  endtask

  initial begin
    int w1, w2, snap;
    rst = 1'b1; rx_data = '0; rx_addr = '0; rx_last = 1'b0; rx_valid = 1'b0; tready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tvalid", tvalid, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_seq", tx_seq, 0);
    check("reset_sop_eop", {tx_sop, tx_eop}, 0);
    check("reset_overflow", overflow, 0);
    check("reset_chunk_err", chunk_err, 0);
    rst = 1'b0;

    // single block latency + write completion coinciding with drain completion
    tready = 1'b1;
    write_block(64'h0, 1, 0);
    w1 = wr_last_cyc;
    idle(4);
    write_block(64'h1_0000_0000, 1, 0);
    w2 = wr_last_cyc;
    write_block(64'h2_0000_0000, 1, 0);
    idle(1);
    settle(20000);
    check("blk1_first_tvalid_cycle", sop_q.size() > 0 ? sop_q[0] : -1, w1 + 6);
    check("blk1_eop_cycle", eop_q.size() > 0 ? eop_q[0] : -1, w2 + 1);
    check("blk2_sop_cycle", sop_q.size() > 1 ? sop_q[1] : -1, w2 + 6);
    check("sop_count_3_blocks", sop_q.size(), 3);
    check("no_overflow_on_handover", n_ovf, 0);
    check("no_chunk_err_clean_blocks", n_cerr, 0);

    // backpressure: one slot every other cycle
    tready = 1'b0; n_words = 0;
    write_block(64'h3_0000_0000, 1, 0);
    idle(1);
    prev_vld = -1; chk_gap = 1'b1;
    for (int i = 0; i < 8000 && sb.size() != 0; i++) begin
      @(negedge clk);
      tready = ~tready;
    end
    chk_gap = 1'b0;
    tready  = 1'b1;
    settle(100);
    check("backpressure_word_count", n_words, BLK);

    // chunk error on chunk 0
    n_cerr = 0;
    write_block(64'h4_0000_0000, 1, 1);
    idle(1);
    settle(5000);
    check("chunk_err_count", n_cerr, 1);
    check("chunk_err_cycle", cerr_cyc, cerr_last_cyc + 1);

    // overflow: third block finds both banks full
    tready = 1'b0; n_ovf = 0; ovf_first = -1;
    write_block(64'h5_0000_0000, 1, 0);
    write_block(64'h6_0000_0000, 1, 0);
    write_block(64'h7_0000_0000, 0, 0);
    idle(2);
    check("overflow_pulse_count", n_ovf, BLK);
    check("overflow_first_cycle", ovf_first, wr_first_cyc + 1);
    sop_q.delete();
    tready = 1'b1;
    settle(10000);
    check("overflow_replay_blocks", sop_q.size(), 2);

    // reset during readout
    n_words = 0;
    write_block(64'h8_0000_0000, 1, 0);
    idle(1);
    for (int i = 0; i < 4000 && n_words < 1000; i++) @(negedge clk);
    check("reached_word_1000", n_words >= 1000, 1);
    snap = n_words;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    idle(20);
    check("no_tvalid_after_reset", n_words, snap);
    tready = 1'b0; n_ovf = 0;
    write_block(64'h9_0000_0000, 1, 0);
    write_block(64'hA_0000_0000, 1, 0);
    idle(2);
    check("both_banks_free_after_reset", n_ovf, 0);
    sop_q.delete();
    tready = 1'b1;
    settle(10000);
    check("post_reset_blocks", sop_q.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
